// File: rtl/key_input_ctrl.sv
//==============================================================================
// key_input_ctrl : debounces active-low keys into levels plus press, release
//                  and long-press pulses. Optional macro KEY_REPEAT_EN adds
//                  auto-repeat press pulses after the long-press event.
// Revision 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module key_input_ctrl #(
  parameter int CLK_IN_FREQ = 27000000,
  parameter int NUM_KEYS    = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] key_state_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic [NUM_KEYS-1:0] key_long_o
);

  localparam int c_TICK_DIV = CLK_IN_FREQ / 1000;
  localparam int DIV_W      = $clog2(c_TICK_DIV) + 1;
  localparam int DB_W       = $clog2(DEBOUNCE_MS) + 1;
  localparam int HOLD_W     = $clog2(LONG_MS) + 1;

  localparam logic [DIV_W-1:0]  c_DIV_LAST  = DIV_W'(c_TICK_DIV - 1);
  localparam logic [DB_W-1:0]   c_DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] c_LONG      = HOLD_W'(LONG_MS);
  localparam logic [HOLD_W-1:0] c_LONG_LAST = HOLD_W'(LONG_MS - 1);

  if (LONG_MS <= DEBOUNCE_MS) begin : g_err_long
    $error("key_input_ctrl: LONG_MS must exceed DEBOUNCE_MS");
  end
  if ((CLK_IN_FREQ % 1000 != 0) || (CLK_IN_FREQ < 1000)) begin : g_err_freq
    $error("key_input_ctrl: CLK_IN_FREQ must be a multiple of 1000 and >= 1000");
  end
  if ((NUM_KEYS < 1) || (NUM_KEYS > 8) || (DEBOUNCE_MS < 1) || (REPEAT_MS < 1)) begin : g_err_range
    $error("key_input_ctrl: NUM_KEYS, DEBOUNCE_MS or REPEAT_MS out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_HELD     = 2'd2,
    S_REL_DB   = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_raw;
  logic [DIV_W-1:0]    r_div;
  logic                w_tick;

  // Pins are asynchronous; the reset value of 1 reads as "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw  = ~r_sync2;
  assign w_tick = (r_div == c_DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DB_W-1:0]   r_cnt;
    logic [DB_W-1:0]   w_cnt_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_press;
    logic              w_release;
    logic              w_long;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_long;
`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_MS) + 1;
    localparam logic [REP_W-1:0] c_REP_LAST = REP_W'(REPEAT_MS - 1);
    logic [REP_W-1:0]  r_rep;
    logic [REP_W-1:0]  w_rep_nxt;
`endif

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hold_nxt  = r_hold;
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_long      = 1'b0;
`ifdef KEY_REPEAT_EN
      w_rep_nxt   = r_rep;
`endif
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (w_raw[k]) w_state_nxt = S_PRESS_DB;
        end
        S_PRESS_DB: begin
          if (!w_raw[k]) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == c_DB_LAST) begin
              w_state_nxt = S_HELD;
              w_cnt_nxt   = '0;
              w_hold_nxt  = '0;
              w_press     = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + DB_W'(1);
            end
          end
        end
        S_HELD: begin
          // Hold counter saturates at LONG_MS so the long pulse fires once.
          if (w_tick && (r_hold != c_LONG)) begin
            w_hold_nxt = r_hold + HOLD_W'(1);
            w_long     = (r_hold == c_LONG_LAST);
          end
`ifdef KEY_REPEAT_EN
          if (w_tick && (r_hold == c_LONG)) begin
            if (r_rep == c_REP_LAST) begin
              w_rep_nxt = '0;
              w_press   = 1'b1;
            end else begin
              w_rep_nxt = r_rep + REP_W'(1);
            end
          end
`endif
          if (!w_raw[k]) begin
            w_state_nxt = S_REL_DB;
            w_cnt_nxt   = '0;
          end
        end
        S_REL_DB: begin
          if (w_raw[k]) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == c_DB_LAST) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_hold_nxt  = '0;
              w_release   = 1'b1;
`ifdef KEY_REPEAT_EN
              w_rep_nxt   = '0;
`endif
            end else begin
              w_cnt_nxt = r_cnt + DB_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_hold    <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
        r_rep     <= '0;
`endif
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_hold    <= w_hold_nxt;
        r_level   <= (w_state_nxt == S_HELD) || (w_state_nxt == S_REL_DB);
        r_press   <= w_press;
        r_release <= w_release;
        r_long    <= w_long;
`ifdef KEY_REPEAT_EN
        r_rep     <= w_rep_nxt;
`endif
      end
    end

    assign key_state_o[k]   = r_level;
    assign key_press_o[k]   = r_press;
    assign key_release_o[k] = r_release;
    assign key_long_o[k]    = r_long;
  end

endmodule

`default_nettype wire

// File: tb/tb_key_input_ctrl.sv
//==============================================================================
// tb_key_input_ctrl : scoreboard bench for key_input_ctrl (tick = 10 clk).
// Revision 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_key_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_n = 4'b0000;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  key_input_ctrl #(
    .CLK_IN_FREQ (10000),
    .NUM_KEYS    (4),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20),
    .REPEAT_MS   (5)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n_i       (key_n),
    .key_state_o   (key_state),
    .key_press_o   (key_press),
    .key_release_o (key_release),
    .key_long_o    (key_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pulse_cycles = 0;

  task automatic expect_ev(input string nm, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l, input int lo, input int hi);
    exp_t e;
    e.name = nm; e.prs = p; e.rel = r; e.lng = l; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse cycle must match the oldest expected event and its window.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && cyc > sb[0].hi) begin
        checks++;
        errors++;
        $display("FAIL %s: no event by cycle %0d (now %0d)", sb[0].name, sb[0].hi, cyc);
        void'(sb.pop_front());
      end
      if (|{key_long, key_release, key_press}) begin
        pulse_cycles++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got long=%b rel=%b press=%b at cycle %0d, expected none",
                   key_long, key_release, key_press, cyc);
        end else begin
          mon_e = sb.pop_front();
          if ({key_long, key_release, key_press} !== {mon_e.lng, mon_e.rel, mon_e.prs} ||
              cyc < mon_e.lo || cyc > mon_e.hi) begin
            errors++;
            $display("FAIL %s: got long=%b rel=%b press=%b at cycle %0d, expected long=%b rel=%b press=%b in [%0d,%0d]",
                     mon_e.name, key_long, key_release, key_press, cyc,
                     mon_e.lng, mon_e.rel, mon_e.prs, mon_e.lo, mon_e.hi);
          end
        end
      end
    end
  end

  initial begin
    int t;
    int p0;

    // Reset with all keys pressed: outputs stay 0
    #1 rst_n = 1'b0;
    wait_cyc(5);
    chk("reset_outputs", {16'h0, key_state, key_press, key_release, key_long}, 32'h0);
    key_n = 4'b1111;
    rst_n = 1'b1;
    p0 = pulse_cycles;
    wait_cyc(500);
    chk("idle_no_pulses", pulse_cycles - p0, 0);
    chk("idle_state", {28'h0, key_state}, 32'h0);

    // Clean press and release of key 0
    key_n[0] = 1'b0;
    t = cyc;
    expect_ev("press_k0", 4'b0001, 4'b0000, 4'b0000, t + 32, t + 53);
    wait_cyc(100);
    chk("state_k0_held", {28'h0, key_state}, 32'h1);
    key_n[0] = 1'b1;
    t = cyc;
    expect_ev("release_k0", 4'b0000, 4'b0001, 4'b0000, t + 32, t + 53);
    wait_cyc(100);
    chk("state_k0_released", {28'h0, key_state}, 32'h0);

    // Bounce on key 1: 15-clk segments never satisfy the debounce
    p0 = pulse_cycles;
    for (int i = 0; i < 14; i++) begin
      key_n[1] = ~key_n[1];
      wait_cyc(15);
      chk("bounce_state_k1", {31'h0, key_state[1]}, 32'h0);
    end
    wait_cyc(100);
    chk("bounce_no_pulses", pulse_cycles - p0, 0);

    // Long press on key 2
    key_n[2] = 1'b0;
    t = cyc;
    expect_ev("press_k2", 4'b0100, 4'b0000, 4'b0000, t + 32, t + 53);
    expect_ev("long_k2", 4'b0000, 4'b0000, 4'b0100, t + 222, t + 263);
`ifdef KEY_REPEAT_EN
    for (int k = 1; k <= 4; k++)
      expect_ev("repeat_k2", 4'b0100, 4'b0000, 4'b0000, t + 222 + 50 * k, t + 263 + 50 * k);
`endif
    wait_cyc(460);
    chk("state_k2_held", {28'h0, key_state}, 32'h4);
    key_n[2] = 1'b1;
    t = cyc;
    expect_ev("release_k2", 4'b0000, 4'b0100, 4'b0000, t + 32, t + 53);
    wait_cyc(100);

    // Simultaneous keys 0 and 3, then async reset mid-hold
    key_n = 4'b0110;
    t = cyc;
    expect_ev("press_k03", 4'b1001, 4'b0000, 4'b0000, t + 32, t + 53);
    wait_cyc(80);
    chk("state_k03_held", {28'h0, key_state}, 32'h9);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {16'h0, key_state, key_press, key_release, key_long}, 32'h0);
    wait_cyc(5);
    rst_n = 1'b1;
    t = cyc;
    expect_ev("repress_k03", 4'b1001, 4'b0000, 4'b0000, t + 32, t + 53);
    wait_cyc(80);
    chk("state_k03_after_reset", {28'h0, key_state}, 32'h9);
    key_n = 4'b1111;
    t = cyc;
    expect_ev("release_k03", 4'b0000, 4'b1001, 4'b0000, t + 32, t + 53);
    wait_cyc(100);
    chk("final_state", {28'h0, key_state}, 32'h0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
